counter_ce_sequencer: RTL and testbench

- Sequencing controller for the small CE-gated counter datapath (adder feeding a clock-enabled register bank).
- Generates the counter's CE strobe at a programmable prescaled rate for a programmed number of advances.
- Runs one-shot or periodic, and reports BUSY and DONE to the surrounding logic.
- Sits beside the counter and drives its CE input; the counter's data path is untouched.

---
 rtl/counter_ce_sequencer.sv | 112 +++++++++++
 tb/tb_counter_ce_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/counter_ce_sequencer.sv
// CE strobe sequencer for a clock-enabled counter. It issues COUNT_N strobes spaced
// PRESCALE+1 cycles apart, either one-shot or periodically, and reports BUSY and DONE.
module counter_ce_sequencer #(
    parameter int unsigned PRE_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 MODE,
    input  logic [PRE_WIDTH-1:0] PRESCALE,
    input  logic [CNT_WIDTH-1:0] COUNT_N,
    output logic                 CE,
    output logic                 BUSY,
    output logic                 DONE
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [PRE_WIDTH-1:0]   pre_q, pre_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic                   mode_q, mode_d;
    logic [PRE_WIDTH-1:0]   pre_cfg_q, pre_cfg_d;
    logic [CNT_WIDTH-1:0]   cnt_cfg_q, cnt_cfg_d;
    logic                   ce_q, ce_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        pre_cfg_d = pre_cfg_q;
        cnt_cfg_d = cnt_cfg_q;
        ce_d      = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START && !STOP) begin
                    if (COUNT_N != '0) begin
                        mode_d    = MODE;
                        pre_cfg_d = PRESCALE;
                        cnt_cfg_d = COUNT_N;
                        pre_d     = PRESCALE;
                        rem_d     = COUNT_N;
                        state_d   = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (STOP) begin
                    state_d = StIdle;
                    pre_d   = '0;
                    rem_d   = '0;
                end else if (rem_q == '0) begin
                    // One-shot run ends here: this is the cycle carrying the final CE.
                    state_d = StIdle;
                    pre_d   = '0;
                end else if (pre_q == '0) begin
                    ce_d  = 1'b1;
                    pre_d = pre_cfg_q;
                    if (rem_q == CNT_WIDTH'(1)) begin
                        done_d = 1'b1;
                        rem_d  = mode_q ? cnt_cfg_q : '0;
                    end else begin
                        rem_d = rem_q - CNT_WIDTH'(1);
                    end
                end else begin
                    pre_d = pre_q - PRE_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            rem_q     <= '0;
            mode_q    <= 1'b0;
            pre_cfg_q <= '0;
            cnt_cfg_q <= '0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            rem_q     <= rem_d;
            mode_q    <= mode_d;
            pre_cfg_q <= pre_cfg_d;
            cnt_cfg_q <= cnt_cfg_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CE   = ce_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_counter_ce_sequencer.sv
// Directed bench for counter_ce_sequencer: a cycle-by-cycle vector table plus
// hand-written periodic, STOP-collision and reset-mid-run sequences.
module tb_counter_ce_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] prescale;
    logic [3:0] count_n;
    logic       ce;
    logic       busy;
    logic       done;

    int tests;
    int failed;

    counter_ce_sequencer #(
        .PRE_WIDTH(4),
        .CNT_WIDTH(4)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .STOP    (stop),
        .MODE    (mode),
        .PRESCALE(prescale),
        .COUNT_N (count_n),
        .CE      (ce),
        .BUSY    (busy),
        .DONE    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp is {CE, BUSY, DONE} observed in the cycle after the inputs are applied.
    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic [3:0] pre;
        logic [3:0] cnt;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic p, input logic m, input logic [3:0] pr,
                       input logic [3:0] cn, input logic [2:0] e, input string n);
        vec_t v;
        v.start = s; v.stop = p; v.mode = m; v.pre = pr; v.cnt = cn; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] exp);
        tests++;
        if ({ce, busy, done} !== exp) begin
            failed++;
            $display("FAIL %s: got ce/busy/done=%b required %b", name, {ce, busy, done}, exp);
        end
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; prescale = '0; count_n = '0;

        // One-shot P=2 N=3; config inputs wiggled during RUN must be ignored.
        add(1, 0, 0, 2, 3, 3'b010, "os_c0");
        add(0, 0, 1, 0, 7, 3'b010, "os_c1");
        add(0, 0, 1, 0, 7, 3'b010, "os_c2");
        add(0, 0, 1, 0, 7, 3'b110, "os_c3_ce1");
        add(0, 0, 1, 0, 7, 3'b010, "os_c4");
        add(0, 0, 1, 0, 7, 3'b010, "os_c5");
        add(0, 0, 1, 0, 7, 3'b110, "os_c6_ce2");
        add(0, 0, 1, 0, 7, 3'b010, "os_c7");
        add(0, 0, 1, 0, 7, 3'b010, "os_c8");
        add(0, 0, 1, 0, 7, 3'b111, "os_c9_ce3_done");
        add(0, 0, 0, 2, 3, 3'b000, "os_c10_idle");
        add(0, 0, 0, 2, 3, 3'b000, "os_c11_idle");
        // Config isolation P=3 N=2, then inputs 0/7 during RUN.
        add(1, 0, 0, 3, 2, 3'b010, "iso_c0");
        add(0, 0, 1, 0, 7, 3'b010, "iso_c1");
        add(0, 0, 1, 0, 7, 3'b010, "iso_c2");
        add(0, 0, 1, 0, 7, 3'b010, "iso_c3");
        add(0, 0, 1, 0, 7, 3'b110, "iso_c4_ce1");
        add(0, 0, 1, 0, 7, 3'b010, "iso_c5");
        add(0, 0, 1, 0, 7, 3'b010, "iso_c6");
        add(0, 0, 1, 0, 7, 3'b010, "iso_c7");
        add(0, 0, 1, 0, 7, 3'b111, "iso_c8_ce2_done");
        add(0, 0, 1, 0, 7, 3'b000, "iso_c9_idle");
        add(0, 0, 0, 0, 7, 3'b000, "iso_c10_idle");
        // Zero count and START/STOP collision in IDLE.
        add(1, 0, 0, 2, 0, 3'b001, "zero_done");
        add(0, 0, 0, 2, 0, 3'b000, "zero_after");
        add(1, 1, 0, 2, 3, 3'b000, "startstop_idle");
        add(0, 0, 0, 2, 3, 3'b000, "startstop_after");
        // START held across one-shot return: one IDLE cycle, then a new run.
        add(1, 0, 0, 0, 1, 3'b010, "held_c0");
        add(1, 0, 0, 0, 1, 3'b111, "held_c1_ce");
        add(1, 0, 0, 0, 1, 3'b000, "held_c2_idle");
        add(1, 0, 0, 0, 1, 3'b010, "held_c3_run");
        add(0, 0, 0, 0, 1, 3'b111, "held_c4_ce");
        add(0, 0, 0, 0, 1, 3'b000, "held_c5_idle");

        step();
        check("reset_state", 3'b000);
        rst = 1'b0;
        step();
        check("post_reset_idle", 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stop = vecs[i].stop; mode = vecs[i].mode;
            prescale = vecs[i].pre; count_n = vecs[i].cnt;
            step();
            check(vecs[i].name, vecs[i].exp);
        end
        start = 1'b0; stop = 1'b0;

        // Periodic P=0 N=4: CE every cycle, DONE on every 4th strobe, STOP after 20.
        start = 1'b1; mode = 1'b1; prescale = 4'd0; count_n = 4'd4;
        step();
        start = 1'b0;
        check("per_c0", 3'b010);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("per_c%0d", k), {2'b11, (k % 4 == 0)});
        end
        stop = 1'b1;
        step();
        check("per_stop", 3'b000);
        stop = 1'b0;
        step();
        check("per_after_stop", 3'b000);

        // STOP on the cycle the second CE is due (P=1 N=2).
        start = 1'b1; mode = 1'b0; prescale = 4'd1; count_n = 4'd2;
        step();
        start = 1'b0;
        check("sc_c0", 3'b010);
        step(); check("sc_c1", 3'b010);
        step(); check("sc_c2_ce1", 3'b110);
        step(); check("sc_c3", 3'b010);
        stop = 1'b1;
        step(); check("sc_c4_suppressed", 3'b000);
        stop = 1'b0;
        step(); check("sc_c5_idle", 3'b000);

        // Reset mid-run after second CE (P=2 N=5).
        start = 1'b1; mode = 1'b0; prescale = 4'd2; count_n = 4'd5;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        check("rm_c6_ce2", 3'b110);
        rst = 1'b1;
        #1;
        check("rm_async_drop", 3'b000);
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("rm_quiet_%0d", k), 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
